// File: rtl/draw_request_arbiter_pkg.sv
// Shared draw-arbiter definitions.
// FSM states and screen defaults reused by the mover/animator FSMs.
package draw_request_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } drw_state_t;

  localparam int DRW_XW      = 9;
  localparam int DRW_YW      = 8;
  localparam int DRW_SPRW    = 3;
  localparam int DRW_TIMEOUT = 50000;
  localparam int DRW_CNTW    = 16;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_request_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Rotates requests to start after i_last, priority-encodes, unrotates.
module draw_request_arbiter_rr_pick
  import draw_request_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [IW-1:0]   o_winner,
  output logic            o_any_req
);

  logic [NREQ-1:0] w_rot;
  logic [IW-1:0]   w_pos;
  int              w_base;

  // Lowest set bit of the rotated vector is the next in turn.
  always_comb begin
    w_base = int'(i_last) + 1;
    w_rot  = '0;
    for (int j = 0; j < NREQ; j++)
      w_rot[j] = i_req[IW'((w_base + j) % NREQ)];
    w_pos = '0;
    for (int j = NREQ - 1; j >= 0; j--)
      if (w_rot[j])
        w_pos = IW'(j);
    o_winner  = IW'((w_base + int'(w_pos)) % NREQ);
    o_any_req = |i_req;
  end

endmodule

// File: rtl/draw_request_arbiter.sv
// Shares one sprite/background drawer among several FSMs.
// Round-robin grant, latched payload, start/done handshake, watchdog.
module draw_request_arbiter
  import draw_request_arbiter_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int XW      = DRW_XW,
  parameter int YW      = DRW_YW,
  parameter int SPRW    = DRW_SPRW,
  parameter int TIMEOUT = DRW_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*XW-1:0]   req_x,
  input  logic [NREQ*YW-1:0]   req_y,
  input  logic [NREQ*SPRW-1:0] req_spr,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 timeout_err,
  output logic                 drw_start,
  output logic [XW-1:0]        drw_x,
  output logic [YW-1:0]        drw_y,
  output logic [SPRW-1:0]      drw_spr,
  input  logic                 drw_done
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = DRW_CNTW;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  drw_state_t      r_state;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic            r_terr;
  logic            r_start;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic [SPRW-1:0] r_spr;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_win;
  logic [CW-1:0]   r_cnt;

  logic [IW-1:0]   w_winner;
  logic            w_any;
  logic [XW-1:0]   w_x;
  logic [YW-1:0]   w_y;
  logic [SPRW-1:0] w_spr;

  draw_request_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req     (req),
    .i_last    (r_last),
    .o_winner  (w_winner),
    .o_any_req (w_any)
  );

  // Select the candidate winner's payload slice.
  always_comb begin
    w_x   = '0;
    w_y   = '0;
    w_spr = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_winner == IW'(i)) begin
        w_x   = req_x[i*XW +: XW];
        w_y   = req_y[i*YW +: YW];
        w_spr = req_spr[i*SPRW +: SPRW];
      end
  end

  // Arbiter FSM; every output is a register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_terr  <= 1'b0;
      r_start <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_spr   <= '0;
      r_last  <= LAST_RST;
      r_win   <= '0;
      r_cnt   <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
      r_terr  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win   <= w_winner;
            r_grant <= NREQ'(1) << w_winner;
            r_x     <= w_x;
            r_y     <= w_y;
            r_spr   <= w_spr;
            r_start <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (drw_done) begin
            r_done  <= r_grant;
            r_state <= DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_done  <= r_grant;
            r_terr  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_last  <= r_win;
          r_grant <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign timeout_err = r_terr;
  assign drw_start   = r_start;
  assign drw_x       = r_x;
  assign drw_y       = r_y;
  assign drw_spr     = r_spr;

endmodule

// File: doc/draw_request_arbiter.md
Name: draw_request_arbiter

Overview:
Shares the single sprite/background drawer between several movement and animation FSMs, for example the character mover's BG-redraw and char-draw requests and the pillar/bridge animators.
- Picks one pending requester round-robin, latches its coordinates and sprite id, and pulses the drawer's start.
- Waits for the drawer's done, then pulses done back to the winner.
- A watchdog aborts a hung draw so no requester can stall the game.

Parameters:
NREQ, 3, number of requesters (2..8)
XW, 9, x-coordinate width (320-wide screen)
YW, 8, y-coordinate width (240-high screen)
SPRW, 3, sprite/background select width
TIMEOUT, 50000, maximum WAIT cycles before abort (fits 16-bit counter)

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
req  in  NREQ  level request; held with its payload until matching done
req_x  in  NREQ*XW  packed x per requester, slice i = requester i
req_y  in  NREQ*YW  packed y per requester
req_spr  in  NREQ*SPRW  packed sprite id per requester
grant  out  NREQ  one-hot, high from START through DONE
done  out  NREQ  one-cycle pulse to the winner
timeout_err  out  1  one-cycle pulse coincident with done when the watchdog fired
drw_start  out  1  one-cycle start to the drawer
drw_x  out  XW  latched x, stable from START until the next grant
drw_y  out  YW  latched y
drw_spr  out  SPRW  latched sprite id
drw_done  in  1  drawer completion, sampled only in WAIT

Behaviour:
- Reset: reset resetn, synchronous, active-low; clock clock.
  - State goes to IDLE.
  - grant, done, timeout_err, drw_start, drw_x, drw_y, drw_spr all become 0.
  - Pointer last=NREQ-1, so requester 0 wins first. Watchdog counter cleared.
  - Reset mid-operation aborts with no done pulse.
- States:
  - IDLE: if req!=0, winner = first set bit scanning last+1, last+2, ... (mod NREQ). Register grant=onehot(winner) and latch its x/y/spr into drw_*; go START. Otherwise stay.
  - START: drw_start=1 for exactly this cycle; clear counter; go WAIT.
  - WAIT:
    - drw_done=1 -> DONE.
    - Otherwise, counter==TIMEOUT-1 -> DONE with abort flag set.
    - Otherwise counter+1.
  - DONE: done[winner]=1 and timeout_err=abort flag for this cycle; last<=winner; grant<=0; abort cleared; go IDLE.
- Latency:
  - req sampled high in IDLE at cycle 0 -> grant and drw_* valid, and drw_start high, in cycle 1.
  - drw_done in cycle k -> done in cycle k+1.
  - Back-to-back service: next drw_start 2 cycles after done.
- Boundary conditions:
  - drw_done outside WAIT, including the START cycle, is ignored.
  - A requester dropping req while granted does not cancel; the draw completes and done still pulses.
  - Payload changes after the IDLE latch are ignored.
  - A requester still high in the IDLE cycle after its done is re-eligible, but ranks last in round-robin order.
  - Simultaneous requests: strict round-robin from last+1; no starvation. Worst-case wait is (NREQ-1) services.
  - Counter is 16 bits. TIMEOUT must be >=2. Abort asserts after exactly TIMEOUT WAIT cycles.
  - NREQ=1 degenerates to pass-through sequencing with the same timing.
- All outputs registered; no combinational path from req or drw_done to any output.

Decomposition:
- Shared package: state localparams (IDLE=0, START=1, WAIT=2, DONE=3), default screen widths XW/YW, and the TIMEOUT default. These are reused by the movement and animation FSMs.
- One sub-module: rr_pick, a combinational round-robin picker.
  - Inputs: req[NREQ], last index.
  - Outputs: winner index and any_req.
  - Implementation: rotate, priority-encode, unrotate.

Test Plan:
1. Reset, then req=3'b001 with x=95, y=221, spr=2 -> cycle 1: grant=001, drw_start=1 (one cycle), drw_x=95, drw_y=221, drw_spr=2. drw_done 10 cycles later -> done=001 for one cycle; grant=000 the cycle after.
2. From reset, req=3'b111 held, drawer answers after 5 cycles -> grant order 001, 010, 100, 001, 010. Each drw_* carries that requester's slice.
3. Fairness: req[1] held continuously; req[0] rises while 1 is in WAIT -> after done[1], requester 0 is granted before 1 again.
4. TIMEOUT=20, no drw_done -> done[w]=1 and timeout_err=1 exactly 20 cycles after entering WAIT. A drw_done pulse 3 cycles later (IDLE) is ignored, with no extra done.
5. resetn low for one cycle during WAIT, then drw_done high -> all outputs 0 and no done pulse. The next request (req=3'b110) grants requester 1, confirming the pointer was reset.
6. drw_done high during the START cycle only -> ignored; stays in WAIT until a later drw_done or timeout.
